bnn_score_layer: RTL and testbench

Final binarized fully-connected layer of the BNN datapath, the producer that feeds the downstream argmax/classifier stage. It accepts one binary activation vector from the upstream layer over a req/ack handshake. It computes ten XNOR-popcount class scores against compile-time weights. It then offers the ten 6-bit scores downstream over the same req/ack protocol, with itself as the sending end.

---
 rtl/bnn_score_layer_if.sv | 39 +++
 rtl/bnn_score_layer.sv | 132 +++++++++++++
 tb/tb_bnn_score_layer.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/bnn_score_layer_if.sv
// rtl/bnn_score_layer_if.sv - handshake and score bus for the BNN score layer
//
// Purpose: groups the upstream receive handshake, the downstream send
// handshake and the ten class scores into one bundle.
// Signals:
//   act_in   upstream binary activations (bit 1 = +1, bit 0 = -1)
//   rcv_ack  upstream asserts while act_in is valid
//   rcv_req  layer is ready to accept a vector
//   snd_req  downstream ready/request
//   snd_ack  layer is offering scores downstream
//   score0..score9  6-bit class scores
// Modports: master = environment side (upstream + downstream peers),
//           slave  = bnn_score_layer side.

interface bnn_score_layer_if #(
  parameter int N_IN = 32
);
  logic [N_IN-1:0] act_in;
  logic            rcv_ack;
  logic            rcv_req;
  logic            snd_req;
  logic            snd_ack;
  logic [5:0]      score0, score1, score2, score3, score4;
  logic [5:0]      score5, score6, score7, score8, score9;

  modport master (
    output act_in, rcv_ack, snd_req,
    input  rcv_req, snd_ack,
    input  score0, score1, score2, score3, score4,
    input  score5, score6, score7, score8, score9
  );

  modport slave (
    input  act_in, rcv_ack, snd_req,
    output rcv_req, snd_ack,
    output score0, score1, score2, score3, score4,
    output score5, score6, score7, score8, score9
  );
endinterface

// File: rtl/bnn_score_layer.sv
// rtl/bnn_score_layer.sv - final binarized FC layer producing ten XNOR-popcount class scores
//
// Purpose: accepts one activation vector over rcv_req/rcv_ack, computes
// score_k = popcount(~(act ^ W_k)) for k = 0..9 against compile-time
// weights, then offers the scores downstream over snd_req/snd_ack.
// Ports:
//   clk   clock, all state changes on the rising edge
//   xrst  synchronous active-low reset
//   bus   bnn_score_layer_if.slave (act_in, rcv_ack, rcv_req, snd_req,
//         snd_ack, score0..score9)
// Configuration macro: BNN_SCORE_PARALLEL_EN
//   defined   - all ten scores computed at once, one ST_CALC cycle
//   undefined - one class per cycle, ten ST_CALC cycles (default)

module bnn_score_layer #(
  parameter int                 N_IN    = 32,
  parameter logic [10*N_IN-1:0] WEIGHTS = '0
) (
  input logic              clk,
  input logic              xrst,
  bnn_score_layer_if.slave bus
);

  typedef enum logic [2:0] {
    ST_WAIT     = 3'd0,
    ST_RCV      = 3'd1,
    ST_CALC     = 3'd2,
    ST_SND_WAIT = 3'd3,
    ST_SND      = 3'd4
  } state_t;

  state_t          r_state;
  logic [N_IN-1:0] r_act;
  logic [5:0]      r_score [10];

  // Matching-bit count; N_IN <= 63 keeps the result within 6 bits.
  function automatic logic [5:0] f_xnor_pop(input logic [N_IN-1:0] a,
                                            input logic [N_IN-1:0] w);
    logic [N_IN-1:0] m;
    logic [5:0]      c;
    m = ~(a ^ w);
    c = '0;
    for (int i = 0; i < N_IN; i++) c = c + {5'd0, m[i]};
    return c;
  endfunction

`ifdef BNN_SCORE_PARALLEL_EN
  logic [5:0] w_score [10];

  always_comb begin
    for (int k = 0; k < 10; k++) w_score[k] = f_xnor_pop(r_act, WEIGHTS[k*N_IN +: N_IN]);
  end
`else
  logic [3:0]      r_cnt;
  logic [N_IN-1:0] w_weight;
  logic [5:0]      w_score;

  // One shared popcount; the class counter selects which weight row feeds it.
  always_comb begin
    w_weight = '0;
    for (int k = 0; k < 10; k++) begin
      if (r_cnt == 4'(k)) w_weight = WEIGHTS[k*N_IN +: N_IN];
    end
  end

  assign w_score = f_xnor_pop(r_act, w_weight);
`endif

  always_ff @(posedge clk) begin
    if (!xrst) begin
      r_state <= ST_WAIT;
      r_act   <= '0;
      for (int k = 0; k < 10; k++) r_score[k] <= '0;
`ifndef BNN_SCORE_PARALLEL_EN
      r_cnt   <= '0;
`endif
    end else begin
      case (r_state)
        ST_WAIT: begin
          if (bus.rcv_ack) begin
            r_act   <= bus.act_in;
            r_state <= ST_RCV;
          end
        end
        ST_RCV: begin
          // Wait for upstream to drop ack; act_reg is not re-latched here.
          if (!bus.rcv_ack) begin
`ifndef BNN_SCORE_PARALLEL_EN
            r_cnt   <= '0;
`endif
            r_state <= ST_CALC;
          end
        end
        ST_CALC: begin
`ifdef BNN_SCORE_PARALLEL_EN
          for (int k = 0; k < 10; k++) r_score[k] <= w_score[k];
          r_state <= ST_SND_WAIT;
`else
          for (int k = 0; k < 10; k++) begin
            if (r_cnt == 4'(k)) r_score[k] <= w_score;
          end
          // Counter holds at 9 on the last write so it never leaves 0..9.
          if (r_cnt == 4'd9) r_state <= ST_SND_WAIT;
          else               r_cnt   <= r_cnt + 4'd1;
`endif
        end
        ST_SND_WAIT: begin
          if (bus.snd_req) r_state <= ST_SND;
        end
        ST_SND: begin
          if (!bus.snd_req) r_state <= ST_WAIT;
        end
        default: r_state <= ST_WAIT;
      endcase
    end
  end

  assign bus.rcv_req = (r_state == ST_WAIT);
  assign bus.snd_ack = (r_state == ST_SND);

  assign bus.score0 = r_score[0];
  assign bus.score1 = r_score[1];
  assign bus.score2 = r_score[2];
  assign bus.score3 = r_score[3];
  assign bus.score4 = r_score[4];
  assign bus.score5 = r_score[5];
  assign bus.score6 = r_score[6];
  assign bus.score7 = r_score[7];
  assign bus.score8 = r_score[8];
  assign bus.score9 = r_score[9];

endmodule

// File: tb/tb_bnn_score_layer.sv
// tb/tb_bnn_score_layer.sv - self-checking bench for bnn_score_layer

module tb_bnn_score_layer;
  localparam int N_IN = 32;
  localparam logic [10*N_IN-1:0] WTS =
    (320'hA5A5A5A5 << (3*N_IN)) | (320'h5A5A5A5A << (7*N_IN));
`ifdef BNN_SCORE_PARALLEL_EN
  localparam int CALC_EDGES = 1;
`else
  localparam int CALC_EDGES = 10;
`endif

  logic clk = 1'b0;
  logic xrst = 1'b0;
  always #5 clk = ~clk;

  bnn_score_layer_if #(.N_IN(N_IN)) bus ();

  bnn_score_layer #(.N_IN(N_IN), .WEIGHTS(WTS)) dut (
    .clk  (clk),
    .xrst (xrst),
    .bus  (bus)
  );

  int total = 0;
  int bad   = 0;

  logic [5:0] sc      [10];
  logic [5:0] exp_sc  [10];
  logic [5:0] prev_sc [10];

  assign sc[0] = bus.score0;
  assign sc[1] = bus.score1;
  assign sc[2] = bus.score2;
  assign sc[3] = bus.score3;
  assign sc[4] = bus.score4;
  assign sc[5] = bus.score5;
  assign sc[6] = bus.score6;
  assign sc[7] = bus.score7;
  assign sc[8] = bus.score8;
  assign sc[9] = bus.score9;

  // Score = number of positions where activation and weight agree.
  function automatic logic [5:0] ref_score(input logic [N_IN-1:0] a, input int k);
    logic [N_IN-1:0] w;
    w = WTS[k*N_IN +: N_IN];
    return 6'(N_IN - $countones(a ^ w));
  endfunction

  task automatic set_model(input logic [N_IN-1:0] a);
    for (int k = 0; k < 10; k++) exp_sc[k] = ref_score(a, k);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic chk_scores(input string tag);
    for (int k = 0; k < 10; k++)
      chk($sformatf("%s_score%0d", tag, k), 32'(sc[k]), 32'(exp_sc[k]));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full receive/compute/send round; hold = extra rcv_ack cycles with
  // changing act_in, bp = cycles of snd_req=0 after the compute ends.
  task automatic txn(input logic [N_IN-1:0] a, input int hold, input int bp);
    set_model(a);
    chk("idle_rcv_req", 32'(bus.rcv_req), 32'd1);
    bus.act_in  = a;
    bus.rcv_ack = 1'b1;
    bus.snd_req = (bp == 0);
    step();
    chk("e0_rcv_req", 32'(bus.rcv_req), 32'd0);
    for (int i = 0; i < hold; i++) begin
      bus.act_in = $urandom;
      step();
      chk("hold_rcv_req", 32'(bus.rcv_req), 32'd0);
    end
    bus.rcv_ack = 1'b0;
    bus.act_in  = $urandom;
    step();
    for (int i = 0; i < CALC_EDGES; i++) step();
    chk("calc_end_snd_ack", 32'(bus.snd_ack), 32'd0);
    chk("calc_end_rcv_req", 32'(bus.rcv_req), 32'd0);
    for (int i = 0; i < bp; i++) begin
      bus.rcv_ack = 1'($urandom);
      bus.act_in  = $urandom;
      step();
      chk("bp_snd_ack", 32'(bus.snd_ack), 32'd0);
      chk("bp_rcv_req", 32'(bus.rcv_req), 32'd0);
    end
    if (bp > 0) chk_scores("bp");
    bus.rcv_ack = 1'b0;
    bus.snd_req = 1'b1;
    step();
    chk("snd_ack_rise", 32'(bus.snd_ack), 32'd1);
    chk_scores("snd");
    bus.snd_req = 1'b0;
    step();
    chk("post_rcv_req", 32'(bus.rcv_req), 32'd1);
    chk("post_snd_ack", 32'(bus.snd_ack), 32'd0);
    chk_scores("post");
    prev_sc = exp_sc;
  endtask

  initial begin
    logic [N_IN-1:0] a;

    bus.act_in  = $urandom;
    bus.rcv_ack = 1'($urandom);
    bus.snd_req = 1'($urandom);
    for (int k = 0; k < 10; k++) exp_sc[k] = 6'd0;

    // Reset held for two edges with random inputs.
    xrst = 1'b0;
    for (int r = 0; r < 2; r++) begin
      step();
      chk("rst_rcv_req", 32'(bus.rcv_req), 32'd1);
      chk("rst_snd_ack", 32'(bus.snd_ack), 32'd0);
      chk_scores("rst");
      bus.act_in  = $urandom;
      bus.rcv_ack = 1'($urandom);
      bus.snd_req = 1'($urandom);
    end
    bus.rcv_ack = 1'b0;
    bus.snd_req = 1'b0;
    xrst = 1'b1;
    prev_sc = exp_sc;

    // Directed vectors, nominal timing.
    txn(32'h00000000, 0, 0);
    txn(32'hFFFFFFFF, 0, 0);
    txn(32'hA5A5A5A5, 0, 0);

    // Upstream hold with changing act_in, then long backpressure.
    txn($urandom, 5, 0);
    txn($urandom, 0, 50);

    // Reset in the middle of the compute phase.
    a = $urandom;
    set_model(a);
    bus.act_in  = a;
    bus.rcv_ack = 1'b1;
    bus.snd_req = 1'b0;
    step();
    bus.rcv_ack = 1'b0;
    step();
    for (int i = 0; i < 4; i++) step();
`ifndef BNN_SCORE_PARALLEL_EN
    for (int k = 0; k < 4; k++)
      chk($sformatf("partial_new_score%0d", k), 32'(sc[k]), 32'(exp_sc[k]));
    for (int k = 4; k < 10; k++)
      chk($sformatf("partial_old_score%0d", k), 32'(sc[k]), 32'(prev_sc[k]));
`endif
    xrst = 1'b0;
    step();
    for (int k = 0; k < 10; k++) exp_sc[k] = 6'd0;
    chk("midrst_rcv_req", 32'(bus.rcv_req), 32'd1);
    chk("midrst_snd_ack", 32'(bus.snd_ack), 32'd0);
    chk_scores("midrst");
    xrst = 1'b1;
    prev_sc = exp_sc;

    txn($urandom, 0, 0);

    // Random rounds with random hold and backpressure.
    for (int t = 0; t < 6; t++)
      txn($urandom, $urandom_range(0, 2), $urandom_range(0, 3));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
